parity_rr_arbiter: RTL and testbench

Round-robin arbiter that shares a single registered 8-bit even-parity unit between `NREQ` requesters. Each requester presents a byte with `req`. The block grants one requester per cycle and computes the parity of the granted byte. It returns the result, tagged with the requester index, through a one-entry output slot with valid/ready backpressure. It sits between the byte producers and the parity consumer, so those producers need no parity logic of their own.

---
 rtl/parity_rr_arbiter_if.sv | 44 ++++
 rtl/parity_rr_arbiter.sv | 102 ++++++++++
 tb/tb_parity_rr_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/parity_rr_arbiter_if.sv
// Requester/result bus between byte producers, the parity arbiter and the parity consumer.
// Latency: none (wires only).
// Backpressure: out_rdy from the consumer side; producers see it only through gnt.
interface parity_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] din;
    logic [NREQ-1:0]    gnt;
    logic               out_vld;
    logic               out_rdy;
    logic [DW-1:0]      out_data;
    logic               out_par;
    logic [IDW-1:0]     out_id;
`ifdef PAR_ARB_LOCK_EN
    logic [NREQ-1:0]    lock;

    // Producer/consumer side
    modport master (
        output req, din, out_rdy, lock,
        input  gnt, out_vld, out_data, out_par, out_id
    );

    // Arbiter side
    modport slave (
        input  req, din, out_rdy, lock,
        output gnt, out_vld, out_data, out_par, out_id
    );
`else
    // Producer/consumer side
    modport master (
        output req, din, out_rdy,
        input  gnt, out_vld, out_data, out_par, out_id
    );

    // Arbiter side
    modport slave (
        input  req, din, out_rdy,
        output gnt, out_vld, out_data, out_par, out_id
    );
`endif
endinterface

// File: rtl/parity_rr_arbiter.sv
// Round-robin arbiter sharing one registered even-parity unit between NREQ byte requesters.
// Latency: grant in cycle N, tagged result in the output slot in cycle N+1; one result per cycle.
// Backpressure: a FULL slot with out_rdy=0 suppresses all grants; drain and capture may share an edge.
// Optional burst lock is built when the macro PAR_ARB_LOCK_EN is defined.
module parity_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    parity_rr_arbiter_if.slave bus
);

    logic            accept;
    logic [NREQ-1:0] eff_req;
    logic            gnt_vld;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  nxt_idx;
    logic [IDW-1:0]  ptr;
    logic [IDW:0]    cand;

`ifdef PAR_ARB_LOCK_EN
    typedef enum logic {UNLOCKED, LOCKED} lock_st_t;
    lock_st_t       lock_st;
    logic [IDW-1:0] owner;
`endif

    // The slot can take a new result when empty or when it is being drained this cycle.
    assign accept = !bus.out_vld || bus.out_rdy;

    // While a burst is locked only its owner is visible to the search.
    always_comb begin
        eff_req = bus.req;
`ifdef PAR_ARB_LOCK_EN
        if (lock_st == LOCKED) begin
            eff_req = bus.req & (NREQ'(1) << owner);
        end
`endif
    end

    // First requesting index at or above ptr, wrapping modulo NREQ; nothing in reset or when stalled.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!gnt_vld && !rst && accept && eff_req[cand[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
    end

    assign nxt_idx = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
    assign bus.gnt = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;

    // Output slot, rotation pointer and (optionally) burst-lock state.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_vld  <= 1'b0;
            bus.out_data <= '0;
            bus.out_par  <= 1'b0;
            bus.out_id   <= '0;
            ptr          <= '0;
`ifdef PAR_ARB_LOCK_EN
            lock_st      <= UNLOCKED;
            owner        <= '0;
`endif
        end else begin
            if (gnt_vld) begin
                bus.out_vld  <= 1'b1;
                bus.out_data <= bus.din[gnt_idx*DW +: DW];
                bus.out_par  <= ^bus.din[gnt_idx*DW +: DW];
                bus.out_id   <= gnt_idx;
`ifdef PAR_ARB_LOCK_EN
                // ptr freezes for the whole burst and moves past the owner on its last beat.
                if (lock_st == UNLOCKED) begin
                    if (bus.lock[gnt_idx]) begin
                        lock_st <= LOCKED;
                        owner   <= gnt_idx;
                    end else begin
                        ptr <= nxt_idx;
                    end
                end else if (!bus.lock[gnt_idx]) begin
                    lock_st <= UNLOCKED;
                    ptr     <= nxt_idx;
                end
`else
                ptr <= nxt_idx;
`endif
            end else if (bus.out_vld && bus.out_rdy) begin
                bus.out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parity_rr_arbiter.sv
// Self-checking bench for parity_rr_arbiter: directed vector table, lock burst sequence, random vs. model.
// Latency: checks gnt before each edge and the slot one step after it.
// Backpressure: out_rdy is driven from the table or randomly.
module tb_parity_rr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    parity_rr_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();
    parity_rr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [3:0]  req;
        logic [31:0] din;
        logic        rdy;
        logic [3:0]  gnt;
        logic        vld;
        logic [7:0]  data;
        logic        par;
        logic [1:0]  id;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive inputs just after the falling edge, then let combinational gnt settle.
    task automatic apply_in(input logic r, input logic [3:0] rq, input logic [31:0] d,
                            input logic rd, input logic [3:0] lk);
        @(negedge clk);
        rst         = r;
        bus.req     = rq;
        bus.din     = d;
        bus.out_rdy = rd;
`ifdef PAR_ARB_LOCK_EN
        bus.lock    = lk;
`else
        if (lk != 4'b0) $display("note: lock ignored in this build");
`endif
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic even_par(input logic [7:0] b);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(b[i]);
        return (n % 2) == 1;
    endfunction

    // Random-phase model state
    int          ptr_m;
    logic        vld_m;
    logic [7:0]  data_m;
    logic        par_m;
    logic [1:0]  id_m;
    logic [3:0]  pend;
    logic [7:0]  pdin [NREQ];

    initial begin
        rst = 1'b1;
        bus.req = '0; bus.din = '0; bus.out_rdy = 1'b0;
`ifdef PAR_ARB_LOCK_EN
        bus.lock = '0;
`endif
        // reset held 2 cycles with all requests up
        vecs.push_back(vec_t'{1, 4'hF, 32'hFF070301, 1, 4'b0000, 0, 8'h00, 0, 2'd0});
        vecs.push_back(vec_t'{1, 4'hF, 32'hFF070301, 1, 4'b0000, 0, 8'h00, 0, 2'd0});
        // rotation 0,1,2,3,0 back-to-back
        vecs.push_back(vec_t'{0, 4'hF, 32'hFF070301, 1, 4'b0001, 1, 8'h01, 1, 2'd0});
        vecs.push_back(vec_t'{0, 4'hF, 32'hFF070301, 1, 4'b0010, 1, 8'h03, 0, 2'd1});
        vecs.push_back(vec_t'{0, 4'hF, 32'hFF070301, 1, 4'b0100, 1, 8'h07, 1, 2'd2});
        vecs.push_back(vec_t'{0, 4'hF, 32'hFF070301, 1, 4'b1000, 1, 8'hFF, 0, 2'd3});
        vecs.push_back(vec_t'{0, 4'hF, 32'hFF070301, 1, 4'b0001, 1, 8'h01, 1, 2'd0});
        // capture A5 from requester 2, then stall 3 cycles
        vecs.push_back(vec_t'{0, 4'b0100, 32'h00A50000, 1, 4'b0100, 1, 8'hA5, 0, 2'd2});
        vecs.push_back(vec_t'{0, 4'b0011, 32'h00002211, 0, 4'b0000, 1, 8'hA5, 0, 2'd2});
        vecs.push_back(vec_t'{0, 4'b0011, 32'h00002211, 0, 4'b0000, 1, 8'hA5, 0, 2'd2});
        vecs.push_back(vec_t'{0, 4'b0011, 32'h00002211, 0, 4'b0000, 1, 8'hA5, 0, 2'd2});
        // drain + capture on the same edge, wrap from ptr=3 to requester 0
        vecs.push_back(vec_t'{0, 4'b0011, 32'h00002211, 1, 4'b0001, 1, 8'h11, 0, 2'd0});
        // reset, then skip idle requesters: 1,3,1
        vecs.push_back(vec_t'{1, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h00, 0, 2'd0});
        vecs.push_back(vec_t'{0, 4'b1010, 32'hE0003C00, 1, 4'b0010, 1, 8'h3C, 0, 2'd1});
        vecs.push_back(vec_t'{0, 4'b1010, 32'hE0003C00, 1, 4'b1000, 1, 8'hE0, 1, 2'd3});
        vecs.push_back(vec_t'{0, 4'b1010, 32'hE0003C00, 1, 4'b0010, 1, 8'h3C, 0, 2'd1});
        // drain with no new grant: data fields hold
        vecs.push_back(vec_t'{0, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h3C, 0, 2'd1});
        vecs.push_back(vec_t'{0, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 8'h3C, 0, 2'd1});
        // empty slot accepts even with out_rdy=0; ptr=2 wraps to 0
        vecs.push_back(vec_t'{0, 4'b0001, 32'h00000080, 0, 4'b0001, 1, 8'h80, 1, 2'd0});
        // reset mid-stream with FULL slot and out_rdy=0
        vecs.push_back(vec_t'{1, 4'hF, 32'hFF070301, 0, 4'b0000, 0, 8'h00, 0, 2'd0});
        vecs.push_back(vec_t'{0, 4'hF, 32'hFF070301, 1, 4'b0001, 1, 8'h01, 1, 2'd0});

        for (int v = 0; v < vecs.size(); v++) begin
            apply_in(vecs[v].r, vecs[v].req, vecs[v].din, vecs[v].rdy, 4'b0);
            chk($sformatf("vec%0d_gnt", v), 32'(bus.gnt), 32'(vecs[v].gnt));
            tick();
            chk($sformatf("vec%0d_vld", v), 32'(bus.out_vld), 32'(vecs[v].vld));
            chk($sformatf("vec%0d_data", v), 32'(bus.out_data), 32'(vecs[v].data));
            chk($sformatf("vec%0d_par", v), 32'(bus.out_par), 32'(vecs[v].par));
            chk($sformatf("vec%0d_id", v), 32'(bus.out_id), 32'(vecs[v].id));
        end

`ifdef PAR_ARB_LOCK_EN
        // Burst lock: requester 1 holds 3 locked beats, releases on the 4th, then 2 is next.
        apply_in(1, 4'b0000, 32'h0, 1, 4'b0000); tick();
        apply_in(0, 4'b0001, 32'hFF070301, 1, 4'b0000);
        chk("lock_pre_gnt", 32'(bus.gnt), 32'h1); tick();
        for (int b = 0; b < 4; b++) begin
            apply_in(0, 4'hF, 32'hFF070301, 1, (b < 3) ? 4'b0010 : 4'b0000);
            chk($sformatf("lock_beat%0d_gnt", b), 32'(bus.gnt), 32'h2);
            tick();
            chk($sformatf("lock_beat%0d_id", b), 32'(bus.out_id), 32'd1);
            chk($sformatf("lock_beat%0d_vld", b), 32'(bus.out_vld), 32'd1);
        end
        apply_in(0, 4'hF, 32'hFF070301, 1, 4'b0000);
        chk("lock_after_gnt", 32'(bus.gnt), 32'h4); tick();
        chk("lock_after_id", 32'(bus.out_id), 32'd2);
`endif

        // Randomized traffic against a reference model of the arbitration rules.
        ptr_m = 0; vld_m = 0; data_m = 0; par_m = 0; id_m = 0; pend = '0;
        for (int i = 0; i < NREQ; i++) pdin[i] = '0;
        for (int c = 0; c < 3000; c++) begin
            logic        r, rd, acc;
            int          g;
            logic [31:0] d;
            r  = (c == 0) || ($urandom_range(0, 59) == 0);
            rd = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pdin[i] = 8'($urandom);
                end
            end
            d = {pdin[3], pdin[2], pdin[1], pdin[0]};
            acc = !vld_m || rd;
            g = -1;
            if (!r && acc) begin
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (ptr_m + k) % NREQ;
                    if (g < 0 && pend[j]) g = j;
                end
            end
            apply_in(r, pend, d, rd, 4'b0);
            chk("rnd_gnt", 32'(bus.gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
            tick();
            if (r) begin
                vld_m = 0; data_m = 0; par_m = 0; id_m = 0; ptr_m = 0;
            end else if (g >= 0) begin
                data_m = pdin[g];
                par_m  = even_par(pdin[g]);
                id_m   = 2'(g);
                vld_m  = 1;
                ptr_m  = (g + 1) % NREQ;
                pend[g] = ($urandom_range(0, 1) == 1);
                if (pend[g]) pdin[g] = 8'($urandom);
            end else if (vld_m && rd) begin
                vld_m = 0;
            end
            chk("rnd_vld", 32'(bus.out_vld), 32'(vld_m));
            chk("rnd_data", 32'(bus.out_data), 32'(data_m));
            chk("rnd_par", 32'(bus.out_par), 32'(par_m));
            chk("rnd_id", 32'(bus.out_id), 32'(id_m));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
